bip_control_unit: RTL and testbench

- Sequencing controller for the accumulator datapath; owns the program counter and the instruction register, and decodes each instruction into the datapath control word: operand `o_signal`, `o_selA`, `o_selB`, `o_WrAcc`, `o_OP`, plus data-RAM read/write strobes.
- Sits between program memory (addressed by `o_pc`) and the datapath; data memory is driven by the datapath's address and data outputs.
- Two-state fetch/execute, so CPI = 2.

---
 rtl/bip_control_unit.sv | 162 ++++++++++++++++
 tb/tb_bip_control_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bip_control_unit.sv
// Fetch/execute sequencer for the accumulator datapath: owns PC and IR and decodes
// the control word. Optional single-step mode: define BIP_CTRL_STEP_EN.
module bip_control_unit #(
  parameter int unsigned OPCODE_W = 5,
  parameter int unsigned OPER_W   = 11,
  parameter int unsigned INSTR_W  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
`ifdef BIP_CTRL_STEP_EN
  input  logic               i_step,
`endif
  input  logic [INSTR_W-1:0] i_instr,
  output logic [OPER_W-1:0]  o_pc,
  output logic [OPER_W-1:0]  o_signal,
  output logic [1:0]         o_selA,
  output logic               o_selB,
  output logic               o_WrAcc,
  output logic               o_OP,
  output logic               o_WrRam,
  output logic               o_RdRam,
  output logic               o_busy,
  output logic               o_halt,
  output logic               o_illegal
);

  if (INSTR_W != OPCODE_W + OPER_W) begin : g_bad_width
    $error("INSTR_W must equal OPCODE_W + OPER_W");
  end

  localparam logic [OPCODE_W-1:0] OP_HLT  = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_STO  = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_LDI  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_SUBI = OPCODE_W'(7);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
`ifdef BIP_CTRL_STEP_EN
    , S_PAUSE
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [OPER_W-1:0]   pc_q;
  logic [INSTR_W-1:0]  ir_q;
  logic                illegal_q;
  logic                pc_inc, illegal_set;
  logic [OPCODE_W-1:0] opcode;
  state_t              after_exec;

`ifdef BIP_CTRL_STEP_EN
  logic step_q;
  logic step_rise;
  assign step_rise  = i_step & ~step_q;
  assign after_exec = S_PAUSE;
`else
  assign after_exec = S_FETCH;
`endif

  assign opcode = ir_q[INSTR_W-1 -: OPCODE_W];

  // State, PC, IR and sticky illegal flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      illegal_q <= 1'b0;
`ifdef BIP_CTRL_STEP_EN
      step_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH) ir_q <= i_instr;
      if (pc_inc) pc_q <= pc_q + OPER_W'(1);
      if (illegal_set) illegal_q <= 1'b1;
`ifdef BIP_CTRL_STEP_EN
      step_q <= i_step;
`endif
    end
  end

  // Next state and control word; control word depends only on state and IR
  always_comb begin
    state_d     = state_q;
    pc_inc      = 1'b0;
    illegal_set = 1'b0;
    o_signal    = '0;
    o_selA      = 2'b00;
    o_selB      = 1'b0;
    o_OP        = 1'b0;
    o_WrAcc     = 1'b0;
    o_WrRam     = 1'b0;
    o_RdRam     = 1'b0;
    case (state_q)
      S_IDLE:  if (i_start) state_d = S_FETCH;
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        o_signal = ir_q[OPER_W-1:0];
        state_d  = after_exec;
        pc_inc   = 1'b1;
        case (opcode)
          OP_HLT: begin
            state_d = S_HALT;
            pc_inc  = 1'b0;
          end
          OP_STO:  o_WrRam = 1'b1;
          OP_LD: begin
            o_WrAcc = 1'b1;
            o_RdRam = 1'b1;
          end
          OP_LDI: begin
            o_selA  = 2'b01;
            o_WrAcc = 1'b1;
          end
          OP_ADD: begin
            o_selA  = 2'b10;
            o_WrAcc = 1'b1;
            o_RdRam = 1'b1;
          end
          OP_ADDI: begin
            o_selA  = 2'b10;
            o_selB  = 1'b1;
            o_WrAcc = 1'b1;
          end
          OP_SUB: begin
            o_selA  = 2'b10;
            o_OP    = 1'b1;
            o_WrAcc = 1'b1;
            o_RdRam = 1'b1;
          end
          OP_SUBI: begin
            o_selA  = 2'b10;
            o_selB  = 1'b1;
            o_OP    = 1'b1;
            o_WrAcc = 1'b1;
          end
          default: illegal_set = 1'b1;
        endcase
      end
      S_HALT: state_d = S_HALT;
`ifdef BIP_CTRL_STEP_EN
      S_PAUSE: if (step_rise) state_d = S_FETCH;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign o_pc      = pc_q;
  assign o_busy    = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign o_halt    = (state_q == S_HALT);
  assign o_illegal = illegal_q;

endmodule

// File: tb/tb_bip_control_unit.sv
// Randomized self-checking bench for bip_control_unit against an instruction-level model.
module tb_bip_control_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
`ifdef BIP_CTRL_STEP_EN
  logic        i_step;
`endif
  logic [15:0] i_instr;
  logic [10:0] o_pc, o_signal;
  logic [1:0]  o_selA;
  logic        o_selB, o_WrAcc, o_OP, o_WrRam, o_RdRam, o_busy, o_halt, o_illegal;

  logic [15:0] prog [2048];
  int          checks = 0;
  int          errors = 0;
  bit          m_ill;

  always #5 i_clk = ~i_clk;

  assign i_instr = prog[o_pc];

  bip_control_unit dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
`ifdef BIP_CTRL_STEP_EN
    .i_step(i_step),
`endif
    .i_instr(i_instr), .o_pc(o_pc), .o_signal(o_signal), .o_selA(o_selA),
    .o_selB(o_selB), .o_WrAcc(o_WrAcc), .o_OP(o_OP), .o_WrRam(o_WrRam),
    .o_RdRam(o_RdRam), .o_busy(o_busy), .o_halt(o_halt), .o_illegal(o_illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] word();
    return {o_selA, o_selB, o_OP, o_WrAcc, o_WrRam, o_RdRam};
  endfunction

  // Expected {selA, selB, OP, WrAcc, WrRam, RdRam} per opcode
  function automatic logic [6:0] exp_word(input logic [4:0] opc);
    case (opc)
      5'd1:    return 7'b00_0_0_0_1_0;
      5'd2:    return 7'b00_0_0_1_0_1;
      5'd3:    return 7'b01_0_0_1_0_0;
      5'd4:    return 7'b10_0_0_1_0_1;
      5'd5:    return 7'b10_1_0_1_0_0;
      5'd6:    return 7'b10_0_1_1_0_1;
      5'd7:    return 7'b10_1_1_1_0_0;
      default: return 7'b0;
    endcase
  endfunction

  task automatic check_quiet(input string tag, input int pc);
    check({tag, "_word"}, 32'(word()), 0);
    check({tag, "_sig"}, 32'(o_signal), 0);
    check({tag, "_pc"}, 32'(o_pc), 32'(pc));
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_start = 1'b0;
    m_ill   = 1'b0;
    repeat (3) begin
      @(negedge i_clk);
      check_quiet("rst", 0);
      check("rst_busy", 32'(o_busy), 0);
      check("rst_halt", 32'(o_halt), 0);
      check("rst_ill", 32'(o_illegal), 0);
    end
    i_rst_n = 1'b1;
  endtask

`ifdef BIP_CTRL_STEP_EN
  // In PAUSE: idle outputs; a held step level must not re-trigger, a fresh rise does.
  task automatic step_over(input int pc);
    check_quiet("pause", pc);
    check("pause_busy", 32'(o_busy), 0);
    i_step = 1'b1;
    @(negedge i_clk);
    i_step = 1'b0;
  endtask
`endif

  // Starts from IDLE and executes up to max_instr instructions; stops on HLT.
  task automatic run(input int max_instr, output int end_pc);
    int         mpc = 0;
    bit         done = 1'b0;
    logic [4:0] opc;
    logic [15:0] ins;
    @(negedge i_clk) i_start = 1'b1;
    @(negedge i_clk) i_start = 1'b0;
    for (int n = 0; n < max_instr && !done; n++) begin
      check_quiet("fetch", mpc);
      check("fetch_busy", 32'(o_busy), 1);
      check("fetch_ill", 32'(o_illegal), 32'(m_ill));
      ins = prog[mpc];
      opc = ins[15:11];
      @(negedge i_clk);
      check("exec_word", 32'(word()), 32'(exp_word(opc)));
      check("exec_sig", 32'(o_signal), 32'(ins[10:0]));
      check("exec_pc", 32'(o_pc), 32'(mpc));
      check("exec_busy", 32'(o_busy), 1);
      check("exec_excl", 32'(o_WrAcc & o_WrRam), 0);
      if (opc == 5'd0) done = 1'b1;
      else begin
        if (opc > 5'd7) m_ill = 1'b1;
        mpc = (mpc + 1) % 2048;
      end
      @(negedge i_clk);
`ifdef BIP_CTRL_STEP_EN
      if (!done) step_over(mpc);
`endif
    end
    if (done) begin
      check("halt", 32'(o_halt), 1);
      check("halt_busy", 32'(o_busy), 0);
      check_quiet("halt", mpc);
    end
    end_pc = mpc;
  endtask

  initial begin
    int pc;
    logic [4:0] o;
    i_rst_n = 1'b0;
    i_start = 1'b0;
`ifdef BIP_CTRL_STEP_EN
    i_step = 1'b0;
`endif
    for (int i = 0; i < 2048; i++) prog[i] = 16'h0;

    // Reset then idle hold
    do_reset();
    repeat (5) begin
      @(negedge i_clk);
      check_quiet("idle", 0);
      check("idle_busy", 32'(o_busy), 0);
      check("idle_halt", 32'(o_halt), 0);
    end

    // Immediate add, then halt held with start ignored
    prog[0] = 16'h1807; prog[1] = 16'h280A; prog[2] = 16'h0000;
    run(10, pc);
    check("imm_end_pc", 32'(pc), 2);
    for (int i = 0; i < 10; i++) begin
      i_start = (i == 3);
      @(negedge i_clk);
      check("hold_halt", 32'(o_halt), 1);
      check("hold_pc", 32'(o_pc), 2);
    end
    i_start = 1'b0;

    // Memory ops
    do_reset();
    prog[0] = 16'h1005; prog[1] = 16'h3006; prog[2] = 16'h0807; prog[3] = 16'h0000;
    run(10, pc);
    check("mem_end_pc", 32'(pc), 3);

    // Random programs with occasional undefined opcodes
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int i = 0; i < 20; i++) begin
        o = ($urandom_range(0, 6) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(1, 7));
        prog[i] = {o, 11'($urandom)};
      end
      prog[20] = {5'd0, 11'($urandom)};
      run(40, pc);
      check("rnd_end_pc", 32'(pc), 20);
    end

    // Illegal NOPs over the full PC range, wrapping back to 0
    do_reset();
    for (int i = 0; i < 2048; i++) prog[i] = {5'h1F, 11'($urandom)};
    run(2049, pc);
    check("wrap_pc", 32'(pc), 1);
    check("wrap_ill", 32'(o_illegal), 1);

    // Asynchronous reset during the EXEC of a store
    do_reset();
    prog[0] = 16'h1801; prog[1] = 16'h0807; prog[2] = 16'h0000;
    @(negedge i_clk) i_start = 1'b1;
    @(negedge i_clk) i_start = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
`ifdef BIP_CTRL_STEP_EN
    step_over(1);
`endif
    @(negedge i_clk);
    check("sto_wrram", 32'(o_WrRam), 1);
    check("sto_pc", 32'(o_pc), 1);
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_wrram", 32'(o_WrRam), 0);
    check("arst_pc", 32'(o_pc), 0);
    check("arst_busy", 32'(o_busy), 0);
    @(negedge i_clk) i_rst_n = 1'b1;
    repeat (2) begin
      @(negedge i_clk);
      check("arst_idle", 32'(o_busy), 0);
      check_quiet("arst", 0);
    end

`ifdef BIP_CTRL_STEP_EN
    // Step held high across several cycles executes a single instruction
    do_reset();
    prog[0] = 16'h1801; prog[1] = 16'h1802; prog[2] = 16'h0000;
    @(negedge i_clk) i_start = 1'b1;
    @(negedge i_clk) i_start = 1'b0;
    repeat (2) @(negedge i_clk);
    check("step_p0", 32'(o_pc), 1);
    i_step = 1'b1;
    repeat (5) @(negedge i_clk);
    i_step = 1'b0;
    check("step_pc", 32'(o_pc), 2);
    check("step_paused", 32'(o_busy), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
